// File: rtl/module_lectura_teclado_if.sv
// rtl/module_lectura_teclado_if.sv - keypad column/row lines and decoded key outputs
interface module_lectura_teclado_if #(
    parameter int WIDTH = 4,
    parameter int ROWS  = 4
);
    localparam int CODE_W = (WIDTH * ROWS > 1) ? $clog2(WIDTH * ROWS) : 1;

    logic [WIDTH-1:0]  col;
    logic [ROWS-1:0]   fil;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_held;

    modport master (output col, output fil, input key_code, input key_valid, input key_held);
    modport slave  (input col, input fil, output key_code, output key_valid, output key_held);
endinterface

// File: rtl/module_lectura_teclado.sv
// rtl/module_lectura_teclado.sv - keypad row reader with per-visit sampling and debounce
module module_lectura_teclado #(
    parameter int   WIDTH          = 4,
    parameter int   ROWS           = 4,
    parameter logic COL_ACTIVE_LOW = 1'b0,
    parameter logic ROW_ACTIVE_LOW = 1'b1,
    parameter int   SETTLE_CYCLES  = 16,
    parameter int   DEBOUNCE_COUNT = 3
) (
    input logic                    clk,
    input logic                    rst,
    module_lectura_teclado_if.slave kbd
);
    localparam int CODE_W = (WIDTH * ROWS > 1) ? $clog2(WIDTH * ROWS) : 1;
    localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW     = $clog2(SETTLE_CYCLES + 1);
    localparam int DW     = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [ROWS-1:0] ROW_IDLE = ROW_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic [ROWS-1:0]   fil_s1, fil_s2, row_n;
    logic [WIDTH-1:0]  col_n, col_q;
    logic [SW-1:0]     settle_cnt;
    logic              sample, col_onehot, row_onehot;
    logic [CW-1:0]     col_idx;
    logic [RW-1:0]     row_idx;
    logic [CODE_W-1:0] code;

    state_t            state;
    logic [DW-1:0]     cnt;
    logic [CODE_W-1:0] cand;
    logic [WIDTH-1:0]  cand_col;
    logic [RW-1:0]     cand_row;
    logic              in_cand, cand_row_act;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q, key_held_q;

    assign row_n = ROW_ACTIVE_LOW ? ~fil_s2 : fil_s2;
    assign col_n = COL_ACTIVE_LOW ? ~kbd.col : kbd.col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fil_s1     <= ROW_IDLE;
            fil_s2     <= ROW_IDLE;
            col_q      <= '0;
            settle_cnt <= '0;
        end else begin
            fil_s1 <= kbd.fil;
            fil_s2 <= fil_s1;
            col_q  <= col_n;
            // Saturating count: the single sample fires on the step into saturation.
            if (col_n != col_q)
                settle_cnt <= '0;
            else if (settle_cnt != SW'(SETTLE_CYCLES))
                settle_cnt <= settle_cnt + SW'(1);
        end
    end

    assign col_onehot = (col_q != '0) && ((col_q & (col_q - WIDTH'(1))) == '0);
    assign row_onehot = (row_n != '0) && ((row_n & (row_n - ROWS'(1))) == '0);
    assign sample     = (col_n == col_q) && (settle_cnt == SW'(SETTLE_CYCLES - 1)) && col_onehot;

    always_comb begin
        col_idx = '0;
        row_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (col_q[i]) col_idx = CW'(i);
        for (int j = 0; j < ROWS; j++)
            if (row_n[j]) row_idx = RW'(j);
    end

    assign code         = CODE_W'(row_idx) * CODE_W'(WIDTH) + CODE_W'(col_idx);
    assign in_cand      = (col_q == cand_col);
    assign cand_row_act = row_n[cand_row];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            cand_col    <= '0;
            cand_row    <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (sample) begin
                case (state)
                    IDLE: begin
                        if (row_onehot) begin
                            cand     <= code;
                            cand_col <= col_q;
                            cand_row <= row_idx;
                            cnt      <= DW'(1);
                            state    <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (in_cand) begin
                            if (row_onehot && code == cand) begin
                                if (cnt + DW'(1) == DW'(DEBOUNCE_COUNT)) begin
                                    key_code_q  <= cand;
                                    key_valid_q <= 1'b1;
                                    key_held_q  <= 1'b1;
                                    cnt         <= '0;
                                    state       <= HELD;
                                end else begin
                                    cnt <= cnt + DW'(1);
                                end
                            end else begin
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end
                    end
                    HELD: begin
                        // Only the candidate row matters; other keys never roll over.
                        if (in_cand && !cand_row_act) begin
                            cnt   <= DW'(1);
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (in_cand) begin
                            if (cand_row_act) begin
                                cnt   <= '0;
                                state <= HELD;
                            end else if (cnt + DW'(1) == DW'(DEBOUNCE_COUNT)) begin
                                cnt        <= '0;
                                key_held_q <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                cnt <= cnt + DW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kbd.key_code  = key_code_q;
    assign kbd.key_valid = key_valid_q;
    assign kbd.key_held  = key_held_q;
endmodule

// File: tb/tb_module_lectura_teclado.sv
// tb/tb_module_lectura_teclado.sv - directed vector bench for the keypad row reader
module tb_module_lectura_teclado;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  fil;
    logic [15:0] pressed;
    logic        fil_force_en;
    logic [3:0]  fil_force;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int base;
    logic dbl_seen = 1'b0;
    logic prev_v = 1'b0;

    typedef struct {
        logic [15:0] pressed;
        int          rounds;
        int          pulses;
        int          code;
        int          held;
    } vec_t;
    vec_t vecs [13];

    always #5 clk = ~clk;

    module_lectura_teclado_if #(.WIDTH(4), .ROWS(4)) kbd ();
    assign kbd.col = col;
    assign kbd.fil = fil;

    module_lectura_teclado #(
        .WIDTH(4), .ROWS(4), .COL_ACTIVE_LOW(1'b0), .ROW_ACTIVE_LOW(1'b1),
        .SETTLE_CYCLES(4), .DEBOUNCE_COUNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kbd(kbd)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        fil = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && col[c]) fil[r] = 1'b0;
        if (fil_force_en) fil = fil_force;
    end

    always @(negedge clk) begin
        if (kbd.key_valid) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_v) dbl_seen = 1'b1;
        end
        prev_v = kbd.key_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic scan_round();
        for (int c = 0; c < 4; c++) begin
            col = 4'(1 << c);
            repeat (20) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_rounds(input int n);
        for (int k = 0; k < n; k++) scan_round();
    endtask

    task automatic check_outs(input string tag, input int pulses, input int code, input int held);
        @(negedge clk);
        check({tag, "_pulses"}, pulse_cnt - base, pulses);
        check({tag, "_code"}, int'(kbd.key_code), code);
        check({tag, "_held"}, int'(kbd.key_held), held);
        check({tag, "_double"}, int'(dbl_seen), 0);
    endtask

    initial begin
        rst = 1'b1;
        col = 4'b0000;
        pressed = 16'h0000;
        fil_force_en = 1'b0;
        fil_force = 4'b1111;

        vecs[0]  = '{16'h0000, 2, 0, 0, 0};
        vecs[1]  = '{16'h0040, 2, 0, 0, 0};
        vecs[2]  = '{16'h0000, 1, 0, 0, 0};
        vecs[3]  = '{16'h0040, 3, 1, 6, 1};
        vecs[4]  = '{16'h0040, 2, 0, 6, 1};
        vecs[5]  = '{16'h0000, 1, 0, 6, 1};
        vecs[6]  = '{16'h0040, 1, 0, 6, 1};
        vecs[7]  = '{16'h1040, 3, 0, 6, 1};
        vecs[8]  = '{16'h0000, 2, 0, 6, 1};
        vecs[9]  = '{16'h0000, 1, 0, 6, 0};
        vecs[10] = '{16'h0202, 4, 0, 6, 0};
        vecs[11] = '{16'h2000, 3, 1, 13, 1};
        vecs[12] = '{16'h0000, 3, 0, 13, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_code", int'(kbd.key_code), 0);
        check("reset_valid", int'(kbd.key_valid), 0);
        check("reset_held", int'(kbd.key_held), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            pressed = vecs[i].pressed;
            base = pulse_cnt;
            run_rounds(vecs[i].rounds);
            check_outs($sformatf("vec%0d", i), vecs[i].pulses, vecs[i].code, vecs[i].held);
        end

        // Asynchronous reset while key 6 is held, asserted between clock edges.
        pressed = 16'h0040;
        base = pulse_cnt;
        run_rounds(3);
        check_outs("hold6", 1, 6, 1);
        col = 4'b0001;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_code", int'(kbd.key_code), 0);
        check("async_rst_valid", int'(kbd.key_valid), 0);
        check("async_rst_held", int'(kbd.key_held), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        pressed = 16'h0000;
        base = pulse_cnt;
        run_rounds(2);
        check_outs("post_rst_idle", 0, 0, 0);

        // Blank and multi-hot column vectors with a row forced active.
        fil_force_en = 1'b1;
        fil_force = 4'b1101;
        base = pulse_cnt;
        col = 4'b0000;
        repeat (100) @(posedge clk);
        #1 col = 4'b0110;
        repeat (100) @(posedge clk);
        #1 fil_force_en = 1'b0;
        check_outs("bad_col", 0, 0, 0);

        // Reset during DEBOUNCE must drop the partial count.
        pressed = 16'h0040;
        base = pulse_cnt;
        run_rounds(2);
        check_outs("deb_partial", 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_rounds(1);
        check_outs("deb_after_rst", 0, 0, 0);
        run_rounds(2);
        check_outs("deb_complete", 1, 6, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
